// File: rtl/lsu_addrcheck_ext.sv
// LSU DC1 address classifier / fault checker, registered into DC2 and DC3.
// Define RV_LSU_FAULT_CAPTURE_EN to build the first-fault capture register.
module lsu_addrcheck_ext #(
  parameter int unsigned NUM_REGIONS = 8,
  parameter bit          DCCM_EN     = 1'b1,
  parameter logic [31:0] DCCM_SADR   = 32'hF004_0000,
  parameter logic [31:0] DCCM_SIZE   = 32'h0001_0000,
  parameter logic [31:0] PIC_SADR    = 32'hF00C_0000,
  parameter logic [31:0] PIC_SIZE    = 32'h0000_8000,
  localparam int unsigned IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          freeze,
  input  logic          scan_mode,
  input  logic          req_valid,
  input  logic          req_dma,
  input  logic [1:0]    req_size,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   mrac,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_sel,
  input  logic [31:0]   cfg_wdata,
  output logic [31:0]   cfg_rdata,
  input  logic          fault_cap_clr,
  output logic          chk_valid_dc2,
  output logic          addr_in_dccm_dc2,
  output logic          addr_in_pic_dc2,
  output logic          addr_external_dc2,
  output logic          access_fault_dc2,
  output logic          misaligned_fault_dc2,
  output logic          is_sideeffects_dc2,
  output logic          is_sideeffects_dc3,
  output logic          fault_cap_valid,
  output logic [31:0]   fault_cap_addr,
  output logic [2:0]    fault_cap_cause
);

  localparam logic [31:0] DCCM_MASK = ~(DCCM_SIZE - 32'd1);
  localparam logic [31:0] PIC_MASK  = ~(PIC_SIZE - 32'd1);
  localparam logic [3:0]  DCCM_RGN  = DCCM_SADR[31:28];
  localparam logic [3:0]  PIC_RGN   = PIC_SADR[31:28];

  logic [31:0] base_tab [NUM_REGIONS];
  logic [31:0] mask_tab [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] ent_en, start_hit, end_hit;

  logic [2:0]  len_m1;
  logic [32:0] end33;
  logic [31:0] end_addr;
  logic        wrap;
  logic        start_in_dccm, end_in_dccm, start_in_pic, end_in_pic;
  logic        start_dccm_rgn, end_dccm_rgn, start_pic_rgn, end_pic_rgn;
  logic        in_dccm, in_pic, external_dc1, sideeff_dc1, unaligned, table_ok;
  logic        f1, f2, f3, f4, f5, f6, gate;
  logic        acc_dc1, mis_dc1;
  logic [2:0]  cause_dc1;
  logic [2:0]  cause_dc2_reg;
  logic [31:0] addr_dc2_reg;
  logic        unused_scan;

  assign unused_scan = scan_mode;

  // Region table: each entry freezes itself once its lock bit is written.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_ent
    logic [31:0] base_reg, mask_reg;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        base_reg <= '0;
        mask_reg <= '0;
      end else if (cfg_we && (cfg_idx == IW'(gi)) && !base_reg[1]) begin
        if (cfg_sel) mask_reg <= cfg_wdata;
        else         base_reg <= cfg_wdata;
      end
    end
    assign base_tab[gi]  = base_reg;
    assign mask_tab[gi]  = mask_reg;
    assign ent_en[gi]    = base_reg[0];
    assign start_hit[gi] = base_reg[0] &
                           ((req_addr | mask_reg) == ({base_reg[31:2], 2'b00} | mask_reg));
    assign end_hit[gi]   = base_reg[0] &
                           ((end_addr | mask_reg) == ({base_reg[31:2], 2'b00} | mask_reg));
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_idx == IW'(i)) cfg_rdata = cfg_sel ? mask_tab[i] : base_tab[i];
    end
  end

  always_comb begin
    case (req_size)
      2'd0:    len_m1 = 3'd0;
      2'd1:    len_m1 = 3'd1;
      default: len_m1 = 3'd3;
    endcase
  end

  assign end33    = {1'b0, req_addr} + {30'd0, len_m1};
  assign end_addr = end33[31:0];
  assign wrap     = end33[32];

  assign start_in_dccm  = DCCM_EN & ((req_addr & DCCM_MASK) == DCCM_SADR);
  assign end_in_dccm    = DCCM_EN & ((end_addr & DCCM_MASK) == DCCM_SADR);
  assign start_in_pic   = (req_addr & PIC_MASK) == PIC_SADR;
  assign end_in_pic     = (end_addr & PIC_MASK) == PIC_SADR;
  assign start_dccm_rgn = DCCM_EN & (req_addr[31:28] == DCCM_RGN);
  assign end_dccm_rgn   = DCCM_EN & (end_addr[31:28] == DCCM_RGN);
  assign start_pic_rgn  = req_addr[31:28] == PIC_RGN;
  assign end_pic_rgn    = end_addr[31:28] == PIC_RGN;

  assign in_dccm      = start_in_dccm & end_in_dccm;
  assign in_pic       = start_in_pic & end_in_pic;
  assign external_dc1 = ~(in_dccm | in_pic);
  assign sideeff_dc1  = mrac[{req_addr[31:28], 1'b1}] & ~(start_dccm_rgn | start_pic_rgn);
  assign unaligned    = ((len_m1 == 3'd1) & req_addr[0]) | ((len_m1 == 3'd3) & (|req_addr[1:0]));
  assign table_ok     = ~(|ent_en) | ((|start_hit) & (|end_hit));

  // An offset miss is an address in the region that lands in neither window.
  assign f1 = (start_dccm_rgn & ~start_in_dccm & ~start_in_pic) |
              (end_dccm_rgn & ~end_in_dccm & ~end_in_pic);
  assign f2 = (start_pic_rgn & ~start_in_pic & ~start_in_dccm) |
              (end_pic_rgn & ~end_in_pic & ~end_in_dccm) |
              (start_in_pic & ((len_m1 != 3'd3) | (|req_addr[1:0])));
  assign f3 = (start_in_dccm ^ end_in_dccm) | (start_in_pic ^ end_in_pic);
  assign f4 = ~start_dccm_rgn & ~start_pic_rgn & ~table_ok;
  assign f5 = external_dc1 & (wrap | (req_addr[31:28] != end_addr[31:28]));
  assign f6 = external_dc1 & sideeff_dc1 & unaligned;

  assign gate    = req_valid & ~req_dma;
  assign acc_dc1 = gate & (f1 | f2 | f3 | f4);
  assign mis_dc1 = gate & (f5 | f6);

  always_comb begin
    cause_dc1 = 3'd0;
    if (gate) begin
      if      (f1) cause_dc1 = 3'd1;
      else if (f2) cause_dc1 = 3'd2;
      else if (f3) cause_dc1 = 3'd3;
      else if (f4) cause_dc1 = 3'd4;
      else if (f5) cause_dc1 = 3'd5;
      else if (f6) cause_dc1 = 3'd6;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      chk_valid_dc2        <= 1'b0;
      addr_in_dccm_dc2     <= 1'b0;
      addr_in_pic_dc2      <= 1'b0;
      addr_external_dc2    <= 1'b0;
      access_fault_dc2     <= 1'b0;
      misaligned_fault_dc2 <= 1'b0;
      is_sideeffects_dc2   <= 1'b0;
      is_sideeffects_dc3   <= 1'b0;
      cause_dc2_reg        <= 3'd0;
      addr_dc2_reg         <= 32'd0;
    end else if (!freeze) begin
      chk_valid_dc2        <= req_valid;
      addr_in_dccm_dc2     <= in_dccm;
      addr_in_pic_dc2      <= in_pic;
      addr_external_dc2    <= external_dc1;
      access_fault_dc2     <= acc_dc1;
      misaligned_fault_dc2 <= mis_dc1;
      is_sideeffects_dc2   <= sideeff_dc1;
      is_sideeffects_dc3   <= is_sideeffects_dc2;
      cause_dc2_reg        <= cause_dc1;
      addr_dc2_reg         <= req_addr;
    end
  end

`ifdef RV_LSU_FAULT_CAPTURE_EN
  logic cap_set;
  // A clear in the same cycle as a new fault re-arms and takes the new fault.
  assign cap_set = chk_valid_dc2 & (access_fault_dc2 | misaligned_fault_dc2) &
                   (~fault_cap_valid | fault_cap_clr);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_cap_valid <= 1'b0;
      fault_cap_addr  <= 32'd0;
      fault_cap_cause <= 3'd0;
    end else if (cap_set) begin
      fault_cap_valid <= 1'b1;
      fault_cap_addr  <= addr_dc2_reg;
      fault_cap_cause <= cause_dc2_reg;
    end else if (fault_cap_clr) begin
      fault_cap_valid <= 1'b0;
      fault_cap_addr  <= 32'd0;
      fault_cap_cause <= 3'd0;
    end
  end
`else
  logic unused_cap;
  assign unused_cap      = ^{fault_cap_clr, addr_dc2_reg, cause_dc2_reg};
  assign fault_cap_valid = 1'b0;
  assign fault_cap_addr  = 32'd0;
  assign fault_cap_cause = 3'd0;
`endif

endmodule
